// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-through, no-write-allocate data cache for
// the M stage. Line replacement is round-robin per set. One stall output
// freezes the pipeline while a refill or a write-through beat is outstanding.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   req_i, wr_i      load/store request from the M stage (wr_i=1 is a store)
//   size_i           00 byte, 01 half, 10/11 word
//   addr_i, wdata_i  byte address and right-aligned store data
//   flush_i          invalidate the whole cache
//   rdata_o          aligned word containing addr_i on a load hit, else 0
//   stall_o          freeze every pipeline stage
//   mem_*            word-wide req/ack port to backing data memory
//   hit_cnt_o        saturating count of load/store hits
//   miss_cnt_o       saturating count of load/store misses
module dcache_sa #(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int SET_W     = $clog2(SETS);
  localparam int WORD_W    = (LINE_WORDS > 1) ? WORD_BITS : 1;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SET_LSB   = 2 + WORD_BITS;
  localparam int TAG_LSB   = 2 + WORD_BITS + SET_W;
  localparam int TAG_W     = ADDR_W - TAG_LSB;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} cacheState;

  cacheState         state, stateNext;
  logic              validBits [SETS][WAYS];
  logic [TAG_W-1:0]  tagArr    [SETS][WAYS];
  logic [31:0]       dataArr   [SETS][WAYS][LINE_WORDS];
  logic [WAY_W-1:0]  rrPtr     [SETS];

  logic [ADDR_W-1:0] reqAddr;
  logic [1:0]        reqSize;
  logic [31:0]       reqData;
  logic [WORD_W-1:0] beat;
  logic [WAY_W-1:0]  victim, storeWay;
  logic              storeHit, doneFlag, flushPending;

  logic [SET_W-1:0]  inSet, reqSet;
  logic [TAG_W-1:0]  inTag;
  logic [WORD_W-1:0] inWord, reqWord;
  logic              lookupHit;
  logic [WAY_W-1:0]  lookupWay;
  logic              countHit, countMiss, takeReq, flushNow, finishTxn;
  logic [3:0]        writeBe;
  logic [31:0]       laneData;

  assign inSet   = addr_i[SET_LSB +: SET_W];
  assign inTag   = addr_i[TAG_LSB +: TAG_W];
  assign inWord  = WORD_W'((addr_i >> 2) & WORD_MASK);
  assign reqSet  = reqAddr[SET_LSB +: SET_W];
  assign reqWord = WORD_W'((reqAddr >> 2) & WORD_MASK);

  // Tag compare of the incoming address against every way of its set.
  always_comb begin
    lookupHit = 1'b0;
    lookupWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validBits[inSet][w] && (tagArr[inSet][w] == inTag)) begin
        lookupHit = 1'b1;
        lookupWay = WAY_W'(w);
      end
    end
  end

  // Store lane steering; misaligned half/word accesses drop the low offset bits.
  always_comb begin
    case (reqSize)
      2'b00: begin
        writeBe  = 4'b0001 << reqAddr[1:0];
        laneData = {4{reqData[7:0]}};
      end
      2'b01: begin
        writeBe  = reqAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{reqData[15:0]}};
      end
      default: begin
        writeBe  = 4'b1111;
        laneData = reqData;
      end
    endcase
  end

  // Next state, stall, memory port and event strobes. doneFlag marks the
  // replay of an instruction whose memory work has already been done, so it
  // is neither counted nor repeated. Outputs are held at reset values while
  // rst is low even if the pipeline keeps req_i asserted.
  always_comb begin
    stateNext   = state;
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    countHit    = 1'b0;
    countMiss   = 1'b0;
    takeReq     = 1'b0;
    flushNow    = 1'b0;
    finishTxn   = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            flushNow = 1'b1;
            stall_o  = req_i;
          end else if (req_i) begin
            if (doneFlag && (wr_i || lookupHit)) begin
              if (!wr_i) rdata_o = dataArr[inSet][lookupWay][inWord];
            end else if (!wr_i && lookupHit) begin
              rdata_o  = dataArr[inSet][lookupWay][inWord];
              countHit = 1'b1;
            end else if (!wr_i) begin
              stall_o   = 1'b1;
              countMiss = 1'b1;
              takeReq   = 1'b1;
              stateNext = REFILL;
            end else begin
              stall_o   = 1'b1;
              countHit  = lookupHit;
              countMiss = !lookupHit;
              takeReq   = 1'b1;
              stateNext = WRITE;
            end
          end
        end
        REFILL: begin
          stall_o    = 1'b1;
          mem_req_o  = 1'b1;
          mem_addr_o = (reqAddr & ~LINE_MASK) | (ADDR_W'(beat) << 2);
          if (mem_ack_i && (beat == LAST_BEAT)) begin
            finishTxn = 1'b1;
            stateNext = IDLE;
          end
        end
        WRITE: begin
          stall_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {reqAddr[ADDR_W-1:2], 2'b00};
          mem_be_o    = writeBe;
          mem_wdata_o = laneData;
          if (mem_ack_i) begin
            finishTxn = 1'b1;
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Control state: FSM, valid bits, round-robin pointers, counters and the
  // latched request. A flush seen mid-transaction is applied as the
  // transaction ends, after the refilled line has been marked valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        rrPtr[s] <= '0;
        for (int w = 0; w < WAYS; w++) validBits[s][w] <= 1'b0;
      end
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
      reqAddr      <= '0;
      reqSize      <= 2'b00;
      reqData      <= '0;
      beat         <= '0;
      victim       <= '0;
      storeWay     <= '0;
      storeHit     <= 1'b0;
      doneFlag     <= 1'b0;
      flushPending <= 1'b0;
    end else begin
      state <= stateNext;
      if (countHit && (hit_cnt_o != 32'hFFFF_FFFF)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (countMiss && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (takeReq) begin
        reqAddr  <= addr_i;
        reqSize  <= size_i;
        reqData  <= wdata_i;
        beat     <= '0;
        victim   <= rrPtr[inSet];
        storeHit <= lookupHit;
        storeWay <= lookupWay;
        if (!wr_i) validBits[inSet][rrPtr[inSet]] <= 1'b0;
      end
      if ((state == REFILL) && mem_ack_i) beat <= beat + WORD_W'(1);
      if ((state == IDLE) && !stall_o) doneFlag <= 1'b0;
      if ((state != IDLE) && flush_i) flushPending <= 1'b1;
      if (finishTxn) begin
        doneFlag     <= 1'b1;
        flushPending <= 1'b0;
        if (state == REFILL) begin
          validBits[reqSet][victim] <= 1'b1;
          rrPtr[reqSet] <= (rrPtr[reqSet] == LAST_WAY) ? '0 : rrPtr[reqSet] + WAY_W'(1);
        end
        if (flushPending || flush_i) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) validBits[s][w] <= 1'b0;
        end
      end
      if (flushNow) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) validBits[s][w] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && mem_ack_i) begin
      dataArr[reqSet][victim][beat] <= mem_rdata_i;
      if (beat == LAST_BEAT) tagArr[reqSet][victim] <= reqAddr[TAG_LSB +: TAG_W];
    end
    if ((state == WRITE) && mem_ack_i && storeHit) begin
      for (int b = 0; b < 4; b++) begin
        if (writeBe[b]) dataArr[reqSet][storeWay][reqWord][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

endmodule
